// File: rtl/bep_pkg.sv
// Shared definitions for the BEP pulse-width word decoder.
//   - default symbol timing (nominal widths and tolerance, in clock cycles)
//   - bit positions inside the err_pulse / err_sticky vectors
//   - timing FSM state encoding
//   - abs_diff helper used by the symbol classifier
package bep_pkg;

  localparam int T0_NOM_DEF = 9;
  localparam int T1_NOM_DEF = 18;
  localparam int TOL_DEF    = 3;

  localparam int ERR_SYMBOL  = 0;
  localparam int ERR_LONG    = 1;
  localparam int ERR_TIMEOUT = 2;
  localparam int ERR_OVERRUN = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_DRAIN = 2'd3
  } bep_state_e;

  // Unsigned distance; ordering the operands avoids any wrap-around.
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/bep_edge_sync.sv
// Input synchroniser with registered edge strobes.
// Ports:
//   clock  in   single clock
//   reset  in   asynchronous, active-high
//   din    in   raw asynchronous line
//   rise   out  1-cycle strobe, one cycle after the synced level goes 0->1
//   fall   out  1-cycle strobe, one cycle after the synced level goes 1->0
module bep_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   level;

  assign level = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= level;
      rise   <= level & ~prev_q;
      fall   <= ~level & prev_q;
    end
  end

endmodule

// File: rtl/bep_pulse_word_decoder.sv
// Pulse-width symbol decoder for the BEP receive path.
// Times each high pulse on the synchronised line, classifies it as a 0 or 1
// symbol, assembles MSB-first words and offers them on a valid/ready port.
// Ports:
//   clock       in   single clock
//   reset       in   asynchronous, active-high; clears all state
//   digital_in  in   raw line, asynchronous to clock
//   enable      in   0 flushes the decoder (output register keeps its word)
//   word_data   out  assembled word, first received bit in MSB
//   word_valid  out  word_data holds an undelivered word
//   word_ready  in   consumer accepts when word_valid && word_ready
//   bit_count   out  bits collected toward the current word
//   err_pulse   out  1-cycle events: [0] symbol, [1] long pulse, [2] timeout, [3] overrun
//   err_sticky  out  OR-accumulated err_pulse
//   err_clear   in   clears err_sticky; a same-cycle new event wins
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | line low, no pulse timing active; waiting for a rising edge
// ST_HIGH  | timing a high pulse in pulse_cnt
// ST_LOW   | timing the gap after a classified pulse in gap_cnt
// ST_DRAIN | pulse saturated; waiting for the line to fall before rearming
module bep_pulse_word_decoder
  import bep_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int T0_NOM       = T0_NOM_DEF,
  parameter int T1_NOM       = T1_NOM_DEF,
  parameter int TOL          = TOL_DEF,
  parameter int WORD_BITS    = 8,
  parameter int IDLE_TIMEOUT = 64,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           digital_in,
  input  logic                           enable,
  output logic [WORD_BITS-1:0]           word_data,
  output logic                           word_valid,
  input  logic                           word_ready,
  output logic [$clog2(WORD_BITS+1)-1:0] bit_count,
  output logic [3:0]                     err_pulse,
  output logic [3:0]                     err_sticky,
  input  logic                           err_clear
);

  localparam int BC_W = $clog2(WORD_BITS+1);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_PRESAT = CNT_MAX - 1'b1;
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(IDLE_TIMEOUT);
  localparam logic [31:0]      T0_U       = 32'(T0_NOM);
  localparam logic [31:0]      T1_U       = 32'(T1_NOM);
  localparam logic [31:0]      TOL_U      = 32'(TOL);
  localparam logic [BC_W-1:0]  LAST_BIT   = BC_W'(WORD_BITS - 1);

  logic rise, fall;

  bep_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clock (clock),
    .reset (reset),
    .din   (digital_in),
    .rise  (rise),
    .fall  (fall)
  );

  bep_state_e           state_q, state_d;
  logic [CNT_W-1:0]     pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [BC_W-1:0]      bit_count_q, bit_count_d;
  logic [WORD_BITS-2:0] shreg_q, shreg_d;
  logic [WORD_BITS-1:0] word_data_q, word_data_d;
  logic                 word_valid_q, word_valid_d;
  logic [3:0]           err_pulse_q, err_d;
  logic [3:0]           err_sticky_q, err_sticky_d;

  // Classifier works on the pulse width held in pulse_cnt when the fall strobe arrives.
  logic [31:0]          d0, d1, d_min;
  logic                 sym_bit, sym_ok;
  logic [WORD_BITS-1:0] shifted;

  always_comb begin
    d0      = abs_diff(32'(pulse_cnt_q), T0_U);
    d1      = abs_diff(32'(pulse_cnt_q), T1_U);
    sym_bit = !(d0 < d1);
    d_min   = sym_bit ? d1 : d0;
    sym_ok  = (d_min <= TOL_U);
    shifted = {shreg_q, sym_bit};
  end

  logic                 word_done;

  always_comb begin
    state_d      = state_q;
    pulse_cnt_d  = pulse_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    bit_count_d  = bit_count_q;
    shreg_d      = shreg_q;
    word_data_d  = word_data_q;
    word_valid_d = word_valid_q;
    err_d        = '0;
    word_done    = 1'b0;

    if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end

    if (!enable) begin
      state_d     = ST_IDLE;
      pulse_cnt_d = '0;
      gap_cnt_d   = '0;
      bit_count_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d     = ST_HIGH;
            pulse_cnt_d = CNT_W'(1);
          end
        end

        ST_HIGH: begin
          if (fall) begin
            state_d   = ST_LOW;
            gap_cnt_d = CNT_W'(1);
            if (sym_ok) begin
              shreg_d = shifted[WORD_BITS-2:0];
              if (bit_count_q == LAST_BIT) begin
                word_done   = 1'b1;
                bit_count_d = '0;
              end else begin
                bit_count_d = bit_count_q + 1'b1;
              end
            end else begin
              err_d[ERR_SYMBOL] = 1'b1;
              bit_count_d       = '0;
            end
          end else if (pulse_cnt_q == CNT_PRESAT) begin
            // This increment saturates the counter: the pulse is unusable.
            pulse_cnt_d     = CNT_MAX;
            err_d[ERR_LONG] = 1'b1;
            bit_count_d     = '0;
            state_d         = ST_DRAIN;
          end else begin
            pulse_cnt_d = pulse_cnt_q + 1'b1;
          end
        end

        ST_DRAIN: begin
          if (fall) begin
            state_d = ST_IDLE;
          end
        end

        ST_LOW: begin
          if (gap_cnt_q != CNT_MAX) begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
          if (gap_cnt_q == TIMEOUT_C && bit_count_q != '0) begin
            err_d[ERR_TIMEOUT] = 1'b1;
            bit_count_d        = '0;
            state_d            = ST_IDLE;
          end
          // A coincident rising edge still starts a pulse after the timeout.
          if (rise) begin
            state_d     = ST_HIGH;
            pulse_cnt_d = CNT_W'(1);
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    if (word_done) begin
      if (!word_valid_q || word_ready) begin
        word_data_d  = shifted;
        word_valid_d = 1'b1;
      end else begin
        err_d[ERR_OVERRUN] = 1'b1;
      end
    end

    err_sticky_d = (err_clear ? 4'b0000 : err_sticky_q) | err_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pulse_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      bit_count_q  <= '0;
      shreg_q      <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      err_pulse_q  <= '0;
      err_sticky_q <= '0;
    end else begin
      state_q      <= state_d;
      pulse_cnt_q  <= pulse_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      bit_count_q  <= bit_count_d;
      shreg_q      <= shreg_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      err_pulse_q  <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign bit_count  = bit_count_q;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;

endmodule
